// File: rtl/bp_pkg.sv
// Shared constants and table entry layout for the branch target buffer.
// Tag and target fields are sized for the widest supported PC; narrower PCs are zero-extended.
package bp_pkg;

    localparam int BP_MAX_PC_WIDTH = 64;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_OFFSET = 2'b01;
    localparam logic [1:0] PC_RS1    = 2'b10;
    localparam logic [1:0] PC_ZERO   = 2'b11;

    localparam logic [1:0] CTR_SNT = 2'b00;
    localparam logic [1:0] CTR_WNT = 2'b01;
    localparam logic [1:0] CTR_WT  = 2'b10;
    localparam logic [1:0] CTR_ST  = 2'b11;

    typedef struct packed {
        logic                       valid;
        logic [BP_MAX_PC_WIDTH-1:0] tag;
        logic [BP_MAX_PC_WIDTH-1:0] target;
        logic [1:0]                 ctr;
    } bp_entry_t;

endpackage

// File: rtl/branch_predictor_sat_counter2.sv
// Two-bit saturating direction counter next-state logic.
module sat_counter2
    import bp_pkg::*;
(
    input  logic [1:0] ctr,
    input  logic       taken,
    output logic [1:0] ctr_next
);

    // Step towards strongly taken or strongly not-taken, holding at the ends.
    always_comb begin
        ctr_next = ctr;
        if (taken) begin
            if (ctr != CTR_ST) begin
                ctr_next = ctr + 2'd1;
            end else begin
                ctr_next = CTR_ST;
            end
        end else begin
            if (ctr != CTR_SNT) begin
                ctr_next = ctr - 2'd1;
            end else begin
                ctr_next = CTR_SNT;
            end
        end
    end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit direction counters: predicts in IF,
// resolves and trains from EX, and keeps transfer/mispredict statistics.
module branch_predictor
    import bp_pkg::*;
#(
    parameter int ENTRIES   = 16,
    parameter int PC_WIDTH  = 32,
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [PC_WIDTH-1:0]  fetchPc,
    output logic                 predTaken,
    output logic [PC_WIDTH-1:0]  predTarget,
    input  logic                 exValid,
    input  logic [PC_WIDTH-1:0]  exPc,
    input  logic [1:0]           exPcSel,
    input  logic                 exJal,
    input  logic [PC_WIDTH-1:0]  exTarget,
    input  logic                 exPredTaken,
    input  logic [PC_WIDTH-1:0]  exPredTarget,
    output logic                 mispredict,
    output logic [PC_WIDTH-1:0]  redirectPc,
    output logic [CNT_WIDTH-1:0] branchCount,
    output logic [CNT_WIDTH-1:0] missCount
);

    localparam int IDX = $clog2(ENTRIES);

    bp_entry_t                  table_r [ENTRIES];
    logic [IDX-1:0]             fetch_idx_s;
    logic [IDX-1:0]             ex_idx_s;
    logic [BP_MAX_PC_WIDTH-1:0] fetch_tag_s;
    logic [BP_MAX_PC_WIDTH-1:0] ex_tag_s;
    logic                       fetch_hit_s;
    logic [BP_MAX_PC_WIDTH-1:0] pred_target_wide_s;
    logic                       unused_pred_s;
    bp_entry_t                  ex_entry_s;
    logic                       ex_hit_s;
    logic                       actual_taken_s;
    logic [1:0]                 ctr_step_s;
    logic                       wr_en_s;
    bp_entry_t                  wr_entry_s;

    assign fetch_idx_s = fetchPc[IDX+1:2];
    assign ex_idx_s    = exPc[IDX+1:2];
    assign fetch_tag_s = BP_MAX_PC_WIDTH'(fetchPc[PC_WIDTH-1:IDX+2]);
    assign ex_tag_s    = BP_MAX_PC_WIDTH'(exPc[PC_WIDTH-1:IDX+2]);
    assign ex_entry_s  = table_r[ex_idx_s];

    // Lookup from registered state: only a hit with a taken-leaning counter redirects fetch.
    always_comb begin
        fetch_hit_s        = table_r[fetch_idx_s].valid && (table_r[fetch_idx_s].tag == fetch_tag_s);
        predTaken          = 1'b0;
        pred_target_wide_s = BP_MAX_PC_WIDTH'(fetchPc + PC_WIDTH'(4));
        if (fetch_hit_s && table_r[fetch_idx_s].ctr[1]) begin
            predTaken          = 1'b1;
            pred_target_wide_s = table_r[fetch_idx_s].target;
        end else begin
            predTaken          = 1'b0;
        end
    end

    assign predTarget    = pred_target_wide_s[PC_WIDTH-1:0];
    assign unused_pred_s = ^pred_target_wide_s;

    // Resolution of the EX transfer against the prediction it carried.
    always_comb begin
        actual_taken_s = (exPcSel != PC_PLUS4);
        mispredict     = 1'b0;
        redirectPc     = {PC_WIDTH{1'b0}};
        if (exValid) begin
            mispredict = (actual_taken_s != exPredTaken) ||
                         (actual_taken_s && (exPredTarget != exTarget));
            redirectPc = actual_taken_s ? exTarget : (exPc + PC_WIDTH'(4));
        end else begin
            mispredict = 1'b0;
            redirectPc = {PC_WIDTH{1'b0}};
        end
    end

    sat_counter2 u_ctr (
        .ctr      (ex_entry_s.ctr),
        .taken    (actual_taken_s),
        .ctr_next (ctr_step_s)
    );

    // Training: register-indirect transfers are never written, so JALR only corrects via redirect.
    always_comb begin
        ex_hit_s   = ex_entry_s.valid && (ex_entry_s.tag == ex_tag_s);
        wr_en_s    = 1'b0;
        wr_entry_s = ex_entry_s;
        if (exValid && ((exPcSel == PC_PLUS4) || (exPcSel == PC_OFFSET))) begin
            if (ex_hit_s) begin
                wr_en_s        = 1'b1;
                wr_entry_s.ctr = (exJal && actual_taken_s) ? CTR_ST : ctr_step_s;
                if (actual_taken_s) begin
                    wr_entry_s.target = BP_MAX_PC_WIDTH'(exTarget);
                end else begin
                    wr_entry_s.target = ex_entry_s.target;
                end
            end else if (actual_taken_s) begin
                wr_en_s           = 1'b1;
                wr_entry_s.valid  = 1'b1;
                wr_entry_s.tag    = ex_tag_s;
                wr_entry_s.target = BP_MAX_PC_WIDTH'(exTarget);
                wr_entry_s.ctr    = exJal ? CTR_ST : CTR_WT;
            end else begin
                wr_en_s = 1'b0;
            end
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Table state; reset wins over a same-cycle training write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                table_r[i].valid <= 1'b0;
                table_r[i].ctr   <= CTR_SNT;
            end
        end else if (wr_en_s) begin
            table_r[ex_idx_s] <= wr_entry_s;
        end
    end

    // Saturating statistics counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            branchCount <= {CNT_WIDTH{1'b0}};
            missCount   <= {CNT_WIDTH{1'b0}};
        end else if (exValid) begin
            if (!(&branchCount)) begin
                branchCount <= branchCount + CNT_WIDTH'(1);
            end
            if (mispredict && !(&missCount)) begin
                missCount <= missCount + CNT_WIDTH'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench: driver pushes expected outputs from a behavioural BTB model, monitor compares.
module tb_branch_predictor;

    localparam int ENT = 16;
    localparam int IDXB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] fetchPc = 32'h0;
    logic        predTaken;
    logic [31:0] predTarget;
    logic        exValid = 1'b0;
    logic [31:0] exPc = 32'h0;
    logic [1:0]  exPcSel = 2'b00;
    logic        exJal = 1'b0;
    logic [31:0] exTarget = 32'h0;
    logic        exPredTaken = 1'b0;
    logic [31:0] exPredTarget = 32'h0;
    logic        mispredict;
    logic [31:0] redirectPc;
    logic [31:0] branchCount;
    logic [31:0] missCount;

    branch_predictor #(.ENTRIES(ENT), .PC_WIDTH(32), .CNT_WIDTH(32)) dut (
        .clk(clk), .rst(rst), .fetchPc(fetchPc), .predTaken(predTaken), .predTarget(predTarget),
        .exValid(exValid), .exPc(exPc), .exPcSel(exPcSel), .exJal(exJal), .exTarget(exTarget),
        .exPredTaken(exPredTaken), .exPredTarget(exPredTarget), .mispredict(mispredict),
        .redirectPc(redirectPc), .branchCount(branchCount), .missCount(missCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] f;
        logic        pt;
        logic [31:0] ptg;
        logic        mp;
        logic [31:0] rp;
        logic [31:0] bc;
        logic [31:0] mc;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int errors = 0;

    // Behavioural model: per-slot owner PC, target and a 0..3 confidence value.
    bit          m_valid [ENT];
    logic [31:0] m_owner [ENT];
    logic [31:0] m_tgt   [ENT];
    int          m_conf  [ENT];
    longint      m_bc;
    longint      m_mc;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc / 4) % ENT);
    endfunction

    function automatic bit same_line(input logic [31:0] a, input logic [31:0] b);
        return (a >> (IDXB + 2)) == (b >> (IDXB + 2));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < ENT; i++) begin
            m_valid[i] = 1'b0;
            m_conf[i]  = 0;
        end
        m_bc = 0;
        m_mc = 0;
    endtask

    task automatic model_pred(input logic [31:0] f, output logic pt, output logic [31:0] t);
        int s;
        s = slot(f);
        if (m_valid[s] && same_line(m_owner[s], f) && m_conf[s] >= 2) begin
            pt = 1'b1;
            t  = m_tgt[s];
        end else begin
            pt = 1'b0;
            t  = f + 32'd4;
        end
    endtask

    task automatic model_update(input logic r, input logic v, input logic [31:0] pc,
                                input logic [1:0] sel, input logic jal, input logic [31:0] tgt,
                                input logic mp);
        int s;
        bit taken;
        bit hit;
        if (r) begin
            model_reset();
        end else if (v) begin
            taken = (sel != 2'b00);
            if (m_bc < 64'hFFFF_FFFF) m_bc++;
            if (mp && m_mc < 64'hFFFF_FFFF) m_mc++;
            if (sel == 2'b00 || sel == 2'b01) begin
                s   = slot(pc);
                hit = m_valid[s] && same_line(m_owner[s], pc);
                if (hit) begin
                    if (taken) begin
                        m_conf[s] = (m_conf[s] == 3) ? 3 : m_conf[s] + 1;
                        m_tgt[s]  = tgt;
                        if (jal) m_conf[s] = 3;
                    end else begin
                        m_conf[s] = (m_conf[s] == 0) ? 0 : m_conf[s] - 1;
                    end
                end else if (taken) begin
                    m_valid[s] = 1'b1;
                    m_owner[s] = pc;
                    m_tgt[s]   = tgt;
                    m_conf[s]  = jal ? 3 : 2;
                end
            end
        end
    endtask

    task automatic cycle(input logic r, input logic [31:0] f, input logic v, input logic [31:0] pc,
                         input logic [1:0] sel, input logic jal, input logic [31:0] tgt,
                         input logic ept, input logic [31:0] eptg);
        exp_t e;
        bit   taken;
        @(posedge clk);
        #1;
        rst = r; fetchPc = f; exValid = v; exPc = pc; exPcSel = sel; exJal = jal;
        exTarget = tgt; exPredTaken = ept; exPredTarget = eptg;
        e.f = f;
        model_pred(f, e.pt, e.ptg);
        taken = (sel != 2'b00);
        e.mp = v && ((taken != ept) || (taken && eptg != tgt));
        e.rp = v ? (taken ? tgt : pc + 32'd4) : 32'h0;
        e.bc = m_bc[31:0];
        e.mc = m_mc[31:0];
        q.push_back(e);
        model_update(r, v, pc, sel, jal, tgt, e.mp);
    endtask

    task automatic check(input string name, input logic [31:0] f, input logic [31:0] act,
                         input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s fetchPc=%h got=%h want=%h", name, f, act, expv);
        end
    endtask

    // Monitor: compare every cycle that has a pending expectation, away from the clock edge.
    always @(negedge clk) begin
        exp_t e;
        if (q.size() > 0) begin
            e = q.pop_front();
            check("predTaken",   e.f, {31'd0, predTaken},  {31'd0, e.pt});
            check("predTarget",  e.f, predTarget,          e.ptg);
            check("mispredict",  e.f, {31'd0, mispredict}, {31'd0, e.mp});
            check("redirectPc",  e.f, redirectPc,          e.rp);
            check("branchCount", e.f, branchCount,         e.bc);
            check("missCount",   e.f, missCount,           e.mc);
        end
    end

    function automatic logic [31:0] rand_pc();
        return 32'h1000 + (32'($urandom_range(0, 3)) << 6) + (32'($urandom_range(0, 15)) << 2);
    endfunction

    initial begin
        logic [31:0] pc;
        logic [31:0] f;
        logic [31:0] tg;
        logic [31:0] ptg;
        logic [1:0]  sel;
        logic        pt;
        logic        jal;
        int          wait_cycles;

        rst = 1'b1;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state and a not-taken resolution.
        cycle(1'b0, 32'h100, 1'b1, 32'h100, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 32'h100, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        // Taken branch allocates, then predicts.
        cycle(1'b0, 32'h200, 1'b1, 32'h200, 2'b01, 1'b0, 32'h180, 1'b0, 32'h204);
        cycle(1'b0, 32'h200, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        // Saturation up, then down two steps.
        repeat (3) cycle(1'b0, 32'h200, 1'b1, 32'h200, 2'b01, 1'b0, 32'h180, 1'b1, 32'h180);
        cycle(1'b0, 32'h200, 1'b1, 32'h200, 2'b00, 1'b0, 32'h0, 1'b1, 32'h180);
        cycle(1'b0, 32'h200, 1'b1, 32'h200, 2'b00, 1'b0, 32'h0, 1'b1, 32'h180);
        cycle(1'b0, 32'h200, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        // JAL allocates strongly taken; JALR never allocates.
        cycle(1'b0, 32'h300, 1'b1, 32'h300, 2'b01, 1'b1, 32'h400, 1'b0, 32'h304);
        cycle(1'b0, 32'h300, 1'b1, 32'h340, 2'b10, 1'b0, 32'h500, 1'b0, 32'h344);
        cycle(1'b0, 32'h340, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 32'h300, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        // Aliasing: 0x240 evicts 0x200 at the same index.
        cycle(1'b0, 32'h200, 1'b1, 32'h200, 2'b01, 1'b0, 32'h180, 1'b0, 32'h204);
        cycle(1'b0, 32'h200, 1'b1, 32'h240, 2'b01, 1'b0, 32'h260, 1'b0, 32'h244);
        cycle(1'b0, 32'h200, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 32'h240, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        // Reset wins over a same-cycle taken training write.
        cycle(1'b1, 32'h500, 1'b1, 32'h500, 2'b01, 1'b1, 32'h600, 1'b0, 32'h504);
        cycle(1'b0, 32'h500, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);
        cycle(1'b0, 32'h240, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);

        // Randomized traffic over a small PC pool to force hits, aliasing and saturation.
        for (int n = 0; n < 3000; n++) begin
            pc  = rand_pc();
            f   = ($urandom_range(0, 1) == 0) ? pc : rand_pc();
            sel = 2'($urandom_range(0, 3));
            jal = (sel == 2'b01) && ($urandom_range(0, 3) == 0);
            tg  = rand_pc();
            if ($urandom_range(0, 9) < 7) begin
                model_pred(pc, pt, ptg);
            end else begin
                pt  = 1'($urandom_range(0, 1));
                ptg = rand_pc();
            end
            cycle(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0, f,
                  ($urandom_range(0, 4) != 0) ? 1'b1 : 1'b0, pc, sel, jal, tg, pt, ptg);
        end
        cycle(1'b0, 32'h100, 1'b0, 32'h0, 2'b00, 1'b0, 32'h0, 1'b0, 32'h0);

        wait_cycles = 0;
        while (q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain pending=%0d want=0", q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Parametrised direct-mapped branch target buffer with 2-bit saturating direction counters. It replaces the fixed "predict not-taken" fetch behaviour. It predicts the next PC in IF from the fetch PC, then checks each resolved control transfer in EX. The check uses the pcSel encoding produced by the branch decision logic; on a wrong prediction the block flags the mispredict, supplies the redirect PC, and trains its tables.

## Interface
- ENTRIES, 16: table depth; power of two, at least 2. IDX = log2(ENTRIES).
- PC_WIDTH, 32: PC width. Tag = PC[PC_WIDTH-1 : IDX+2].
- CNT_WIDTH, 32: width of the statistics counters.

- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- fetchPc  in  PC_WIDTH  PC of the instruction currently in IF.
- predTaken  out  1  prediction for fetchPc: taken.
- predTarget  out  PC_WIDTH  predicted next PC.
- exValid  in  1  EX holds a control transfer (B-type, JAL, JALR). One-cycle pulse per instruction; the pipeline holds it low while EX is stalled.
- exPc  in  PC_WIDTH  PC of the EX instruction.
- exPcSel  in  2  resolved pcSel: 00 = pc+4, 01 = pc+offset, 10 = rs1+offset, 11 = 0.
- exJal  in  1  the EX instruction is JAL.
- exTarget  in  PC_WIDTH  resolved target when exPcSel != 00.
- exPredTaken, exPredTarget  in  1, PC_WIDTH  the prediction made for this instruction, piped down from IF.
- mispredict  out  1  flush IF/ID and redirect the PC.
- redirectPc  out  PC_WIDTH  correct next PC when mispredict = 1.
- branchCount, missCount  out  CNT_WIDTH  resolved transfers seen, mispredicts seen.

## Operation
- Each entry holds: valid, tag, target, and ctr[1:0].
- Lookup is combinational from registered state, using index fetchPc[IDX+1:2].
  - Hit (valid and tag equal) with ctr[1] = 1: predTaken = 1, predTarget = stored target.
  - Otherwise: predTaken = 0, predTarget = fetchPc + 4 (modulo 2^PC_WIDTH).
- Resolution (combinational, only when exValid = 1):
  - actualTaken = (exPcSel != 00).
  - actualNext = actualTaken ? exTarget : exPc + 4.
  - mispredict = (actualTaken != exPredTaken) or (actualTaken and exPredTarget != exTarget).
  - redirectPc = actualNext.
  - When exValid = 0: mispredict = 0 and redirectPc = 0.
- Training happens at the clock edge when exValid = 1, at index exPc[IDX+1:2].
  - exPcSel 10 or 11: no table write. JALR is never allocated; a stale hit on it is corrected through mispredict only.
  - Hit, taken: ctr increments and saturates at 11; target is written with exTarget.
  - Hit, not taken: ctr decrements and saturates at 00; target is left unchanged.
  - Miss, taken: allocate and overwrite the entry with valid = 1, the new tag, target = exTarget, and ctr = 10 (weakly taken).
  - Miss, not taken: no write.
  - exJal = 1 and taken: ctr is forced to 11 on both hit and allocate.
- Statistics:
  - branchCount increments on every exValid.
  - missCount increments when exValid and mispredict are both 1.
  - Both counters saturate at all-ones.

## Timing
- Prediction: zero-cycle combinational path from fetchPc.
- Resolution: mispredict and redirectPc are combinational in the same cycle as exValid.
- Training becomes visible to lookups on the cycle after the edge.
- Same-index lookup and update in one cycle: the lookup returns the pre-update contents.
- Reset (rst = 1 at an edge, including mid-operation):
  - every valid = 0 and every ctr = 00; tags and targets are don't-care;
  - branchCount = missCount = 0;
  - a training write in that same cycle is discarded, because reset has priority.
  - The combinational outputs follow the reset state from the next cycle: predTaken = 0 and predTarget = fetchPc + 4.
- Aliasing: two PCs with the same index but different tags evict each other; the last allocation wins.

## Structure
- Package bp_pkg holds:
  - the pcSel constants PC_PLUS4 = 00, PC_OFFSET = 01, PC_RS1 = 10, PC_ZERO = 11;
  - the counter constants CTR_SNT = 00, CTR_WNT = 01, CTR_WT = 10, CTR_ST = 11;
  - the entry struct typedef.
- Sub-module sat_counter2 holds the 2-bit saturating next-state logic (inputs ctr and taken; output next ctr).

## Test plan
- Reset, then fetchPc = 0x100 → predTaken = 0, predTarget = 0x104. Drive exValid with exPc = 0x100, exPcSel = 00, exPredTaken = 0 → mispredict = 0, branchCount = 1.
- Branch exPc = 0x200 taken, exPcSel = 01, exTarget = 0x180, exPredTaken = 0 → mispredict = 1, redirectPc = 0x180. Next cycle, fetchPc = 0x200 → predTaken = 1, predTarget = 0x180.
- Saturation at 0x200:
  - three more taken resolutions → ctr = 11;
  - two not-taken resolutions → ctr = 01 and predTaken = 0;
  - the second not-taken (exPredTaken = 1) → mispredict = 1, redirectPc = 0x204.
- JAL at 0x300, exJal = 1, exPcSel = 01 → entry allocated with ctr = 11. JALR at 0x340, exPcSel = 10 → no allocation; fetchPc = 0x340 still predicts 0x344.
- Aliasing with ENTRIES = 16: allocate 0x200, then allocate 0x240 (same index) → a lookup of 0x200 misses.
- rst asserted in the same cycle as a taken exValid → no entry is written and both counters read 0.
